u712_cpu_chip_gate: RTL
=======================

# u712_cpu_chip_gate

CPU-side front end for the chip RAM SDRAM controller in U712. Decodes 68040 transfer starts aimed at chip RAM, re-times them into a registered request (`CHIP_TSn`/`RAMSPACEn`), and synchronises Agnus `DBRn` against the C1/C3 phase clocks to produce the `DBR_SYNC` grant. It converts the controller's `CPU_TACK` into 68040 bus termination (`TAn`, `TBIn`) and, optionally, a timeout bus error (`TEAn`).

## Interface
Parameters:
- `CHIP_TOP`, default 11'h000: value `A[31:21]` must equal for a chip RAM hit.
- `TIMEOUT_CYCLES`, default 8'd255: CLK80 cycles allowed from request to `CPU_TACK`.

Ports:
- `CLK80`  in  1  80 MHz clock; all state updates on the falling edge.
- `RESETn`  in  1  asynchronous active-low reset.
- `TSn`  in  1  68040 transfer start, one CLK80 low pulse, CLK80-synchronous.
- `RnW`  in  1  68040 read/write.
- `SIZ`  in  2  68040 transfer size; 2'b11 is a line transfer.
- `A`  in  12 [31:20]  68040 address, upper bits.
- `AGNUS_REV`  in  1  1 = 8375 (2 MB), 0 = 8372A (1 MB).
- `DBRn`, `C1`, `C3`  in  1 each  Agnus inputs, asynchronous to CLK80.
- `CPU_CYCLE`, `CPU_TACK`  in  1 each  status from the chip RAM controller.
- `CHIP_TSn`  out  1  re-timed transfer start to the controller.
- `RAMSPACEn`  out  1  chip RAM cycle pending or active.
- `DBR_SYNC`  out  1  the CPU may take the current chip slot.
- `TAn`, `TBIn`, `TEAn`  out  1 each  68040 termination.

## Operation
- Synchronisers: `DBRn`, `C1` and `C3` each pass through two flops. Edge detectors act on the second stage.
- Slot window: `slot_open` sets on a synchronised C1 rising edge and clears on a synchronised C3 rising edge. `DBR_SYNC` is the registered value of `slot_open & DBRn_s2`.
- Hit decode:
  - AGNUS_REV=1: hit when `A[31:21]==CHIP_TOP`.
  - AGNUS_REV=0: additionally requires `A[20]==0`.
- State machine (IDLE, REQ, WAIT, TERM, ERR):
  - IDLE: on `!TSn & hit`, go to REQ. Latch `is_line = (SIZ==2'b11)`.
  - REQ: one cycle. `CHIP_TSn=0`, `RAMSPACEn=0`. Go to WAIT.
  - WAIT: `RAMSPACEn` stays 0 and the timeout counter runs.
    - `CPU_TACK=1` goes to TERM.
    - Timeout expiry goes to ERR.
  - TERM: `TAn=0` for one cycle. `TBIn=0` in the same cycle when `is_line`. `RAMSPACEn` returns to 1. Go to IDLE.
  - ERR: `TEAn=0` for one cycle, `RAMSPACEn=1`. Go to IDLE.
- A `TSn` that arrives outside IDLE is ignored. The 68040 cannot legally issue one.
- A non-hit `TSn` produces no outputs.

## Timing
- Reset values: `CHIP_TSn=1`, `RAMSPACEn=1`, `DBR_SYNC=0`, `TAn=1`, `TBIn=1`, `TEAn=1`. State is IDLE, counter is 0, synchroniser flops are 0.
- Request latency: `TSn` sampled low on edge N gives `CHIP_TSn` and `RAMSPACEn` low after edge N+1.
- Termination latency: `CPU_TACK` sampled high on edge M gives `TAn` low after edge M+1, for exactly one cycle.
- `DBR_SYNC` lags `DBRn` by 3 edges: two synchroniser stages plus one output register.
- Timeout counter:
  - 8-bit. Cleared in REQ, increments in WAIT.
  - Expires when it equals `TIMEOUT_CYCLES`.
  - If `CPU_TACK` and expiry occur on the same edge, `CPU_TACK` wins and the block goes to TERM.
- Reset mid-cycle: all outputs are forced to their reset values immediately. No termination is issued.
- A line transfer gets exactly one `TA` with `TBI`. The CPU then re-runs it as longword cycles.

## Configuration
- `U712_CHIP_TIMEOUT_EN` defined: the timeout counter and ERR state are present, as described above.
- `U712_CHIP_TIMEOUT_EN` undefined: no counter, no ERR state. WAIT exits only on `CPU_TACK`. `TEAn` is tied to 1.

## Structure
- Shared package `u712_pkg`:
  - State encoding typedef.
  - `LINE_SIZ = 2'b11`.
  - Default `CHIP_TOP` constant.
- Sub-module `u712_sync2`: 2-flop synchroniser with asynchronous active-low reset, instantiated three times.

## Test plan
- Reset release, then `TSn` low with `A=12'h001`, RnW=1, SIZ=2'b10 → `CHIP_TSn`/`RAMSPACEn` low one edge later. `CPU_TACK` pulse after 10 cycles → one `TAn` low cycle, `TBIn` stays 1, `RAMSPACEn` returns high.
- Line read (SIZ=2'b11) at `A=12'h000` → `TAn` and `TBIn` low in the same single cycle.
- AGNUS_REV=0 with `A=12'h001` (A20=1) → no `CHIP_TSn`, state stays IDLE. The same access with AGNUS_REV=1 → request issued.
- `DBRn` high, then C1 rise, then C3 rise 6 cycles later → `DBR_SYNC` high 3 edges after C1 rise, low 3 edges after C3 rise. With `DBRn` low, `DBR_SYNC` stays 0.
- Macro defined, `CPU_TACK` never asserted → `TEAn` low for one cycle 255 cycles after REQ, then `RAMSPACEn` high. `CPU_TACK` on the expiry edge → `TAn` asserted and `TEAn` stays 1.
- `RESETn` pulled low during WAIT → all outputs return to reset values immediately. The next hit `TSn` after release is served normally.

Source files
------------

// File: rtl/u712_pkg.sv
// ---------------------------------------------------------------------------
// u712_pkg
// Definitions shared by the U712 chip RAM CPU gate:
//   u712_state_e      - encoding of the CPU request state machine
//   LINE_SIZ          - 68040 SIZ code for a line (burst) transfer
//   CHIP_TOP_DEFAULT  - default A[31:21] value that selects chip RAM
// ---------------------------------------------------------------------------
package u712_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_TERM = 3'd3,
    ST_ERR  = 3'd4
  } u712_state_e;

  localparam logic [1:0]  LINE_SIZ         = 2'b11;
  localparam logic [10:0] CHIP_TOP_DEFAULT = 11'h000;

endpackage

// File: rtl/u712_sync2.sv
// ---------------------------------------------------------------------------
// u712_sync2
// Two-flop synchroniser for a single asynchronous input. State updates on
// the falling clock edge, matching the rest of the CPU gate.
// Ports:
//   clk_i   - clock (falling edge active)
//   rst_ni  - asynchronous active-low reset, both stages clear to 0
//   d_i     - asynchronous input
//   q_o     - synchronised output (second stage)
// ---------------------------------------------------------------------------
module u712_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic s1_q;
  logic s2_q;

  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/u712_cpu_chip_gate.sv
// ---------------------------------------------------------------------------
// u712_cpu_chip_gate
// CPU-side front end of the U712 chip RAM controller. Decodes 68040 transfer
// starts hitting chip RAM, re-times them into CHIP_TSn/RAMSPACEn, grants the
// chip slot (DBR_SYNC) from synchronised Agnus DBRn/C1/C3, and terminates the
// 68040 cycle with TAn/TBIn (and TEAn on timeout).
// Optional feature: define U712_CHIP_TIMEOUT_EN to build the timeout counter
// and ERR state; without it WAIT only exits on CPU_TACK and TEAn is tied 1.
// Ports:
//   CLK80, RESETn          - clock (falling edge active), async active-low reset
//   TSn, RnW, SIZ, A       - 68040 transfer start, direction, size, A[31:20]
//   AGNUS_REV              - 1 = 8375 (2 MB chip RAM), 0 = 8372A (1 MB)
//   DBRn, C1, C3           - asynchronous Agnus bus request and phase clocks
//   CPU_CYCLE, CPU_TACK    - status from the chip RAM controller
//   CHIP_TSn, RAMSPACEn    - registered request to the controller
//   DBR_SYNC               - CPU may use the current chip slot
//   TAn, TBIn, TEAn        - 68040 termination
// ---------------------------------------------------------------------------
module u712_cpu_chip_gate
  import u712_pkg::*;
#(
  parameter logic [10:0] CHIP_TOP       = CHIP_TOP_DEFAULT,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255
) (
  input  logic        CLK80,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic        RnW,
  input  logic [1:0]  SIZ,
  input  logic [11:0] A,
  input  logic        AGNUS_REV,
  input  logic        DBRn,
  input  logic        C1,
  input  logic        C3,
  input  logic        CPU_CYCLE,
  input  logic        CPU_TACK,
  output logic        CHIP_TSn,
  output logic        RAMSPACEn,
  output logic        DBR_SYNC,
  output logic        TAn,
  output logic        TBIn,
  output logic        TEAn
);

  // ---------------- Agnus synchronisers and slot window ----------------
  logic dbr_s2, c1_s2, c3_s2;
  logic c1_prev_q, c3_prev_q;
  logic slot_open_q, slot_open_d;
  logic dbr_sync_q;
  logic c1_rise, c3_rise;

  u712_sync2 u_sync_dbr (.clk_i(CLK80), .rst_ni(RESETn), .d_i(DBRn), .q_o(dbr_s2));
  u712_sync2 u_sync_c1  (.clk_i(CLK80), .rst_ni(RESETn), .d_i(C1),   .q_o(c1_s2));
  u712_sync2 u_sync_c3  (.clk_i(CLK80), .rst_ni(RESETn), .d_i(C3),   .q_o(c3_s2));

  assign c1_rise = c1_s2 & ~c1_prev_q;
  assign c3_rise = c3_s2 & ~c3_prev_q;

  // The grant register samples the window's next value so that DBR_SYNC
  // follows DBRn/C1/C3 by exactly one register beyond the synchronisers.
  always_comb begin
    slot_open_d = slot_open_q;
    if (c1_rise) slot_open_d = 1'b1;
    if (c3_rise) slot_open_d = 1'b0;
  end

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      c1_prev_q   <= 1'b0;
      c3_prev_q   <= 1'b0;
      slot_open_q <= 1'b0;
      dbr_sync_q  <= 1'b0;
    end else begin
      c1_prev_q   <= c1_s2;
      c3_prev_q   <= c3_s2;
      slot_open_q <= slot_open_d;
      dbr_sync_q  <= slot_open_d & dbr_s2;
    end
  end

  assign DBR_SYNC = dbr_sync_q;

  // ---------------- Chip RAM hit decode ----------------
  // The 1 MB Agnus only decodes the lower megabyte of the 2 MB window.
  logic hit;
  assign hit = (A[11:1] == CHIP_TOP) && (AGNUS_REV || !A[0]);

  // ---------------- Request state machine ----------------
  u712_state_e state_q, state_d;
  logic        is_line_q, is_line_d;
`ifdef U712_CHIP_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  always_comb begin
    state_d   = state_q;
    is_line_d = is_line_q;
`ifdef U712_CHIP_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!TSn && hit) begin
          state_d   = ST_REQ;
          is_line_d = (SIZ == LINE_SIZ);
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
`ifdef U712_CHIP_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_WAIT: begin
        // CPU_TACK is checked first so it wins over a simultaneous expiry.
        if (CPU_TACK) begin
          state_d = ST_TERM;
        end
`ifdef U712_CHIP_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CYCLES) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      ST_TERM: state_d = ST_IDLE;
`ifdef U712_CHIP_TIMEOUT_EN
      ST_ERR:  state_d = ST_IDLE;
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      state_q   <= ST_IDLE;
      is_line_q <= 1'b0;
`ifdef U712_CHIP_TIMEOUT_EN
      cnt_q     <= 8'd0;
`endif
    end else begin
      state_q   <= state_d;
      is_line_q <= is_line_d;
`ifdef U712_CHIP_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  // ---------------- Registered outputs ----------------
  // Outputs are a registered decode of the current state, giving one edge
  // of latency from TSn/CPU_TACK sampling to the visible strobe.
  logic chip_tsn_q, ramspacen_q, tan_q, tbin_q;

  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) begin
      chip_tsn_q  <= 1'b1;
      ramspacen_q <= 1'b1;
      tan_q       <= 1'b1;
      tbin_q      <= 1'b1;
    end else begin
      chip_tsn_q  <= (state_q != ST_REQ);
      ramspacen_q <= !((state_q == ST_REQ) || (state_q == ST_WAIT));
      tan_q       <= (state_q != ST_TERM);
      tbin_q      <= !((state_q == ST_TERM) && is_line_q);
    end
  end

  assign CHIP_TSn  = chip_tsn_q;
  assign RAMSPACEn = ramspacen_q;
  assign TAn       = tan_q;
  assign TBIn      = tbin_q;

`ifdef U712_CHIP_TIMEOUT_EN
  logic tean_q;
  always_ff @(negedge CLK80 or negedge RESETn) begin
    if (!RESETn) tean_q <= 1'b1;
    else         tean_q <= (state_q != ST_ERR);
  end
  assign TEAn = tean_q;

  logic unused_in;
  assign unused_in = RnW ^ CPU_CYCLE;
`else
  assign TEAn = 1'b1;

  logic unused_in;
  assign unused_in = RnW ^ CPU_CYCLE ^ (^TIMEOUT_CYCLES);
`endif

endmodule
